// File: rtl/excp_flush_ctrl_pkg.sv
// rtl/excp_flush_ctrl_pkg.sv - exception codes, cause-bit indices and sequencer state encoding
package excp_flush_ctrl_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    localparam int CAUSE_ADEF = 0;
    localparam int CAUSE_ALE  = 1;
    localparam int CAUSE_SYS  = 2;
    localparam int CAUSE_BRK  = 3;
    localparam int CAUSE_INE  = 4;
    localparam int CAUSE_IPE  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

endpackage

// File: rtl/excp_prio_enc.sv
// rtl/excp_prio_enc.sv - priority encoder from {has_int, cause bits} to ecode/esubcode/va_error
module excp_prio_enc
    import excp_flush_ctrl_pkg::*;
#(
    parameter int NCAUSE = 6
) (
    input  logic              has_int,
    input  logic [NCAUSE-1:0] excp,
    output logic [5:0]        ecode,
    output logic [8:0]        esubcode,
    output logic              va_error
);

    always_comb begin
        ecode    = ECODE_INT;
        esubcode = ESUBCODE_NONE;
        va_error = 1'b0;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (excp[CAUSE_ADEF]) begin
            ecode    = ECODE_ADEF;
            va_error = 1'b1;
        end else if (excp[CAUSE_ALE]) begin
            ecode    = ECODE_ALE;
            va_error = 1'b1;
        end else if (excp[CAUSE_SYS]) begin
            ecode = ECODE_SYS;
        end else if (excp[CAUSE_BRK]) begin
            ecode = ECODE_BRK;
        end else if (excp[CAUSE_INE]) begin
            ecode = ECODE_INE;
        end else if (excp[CAUSE_IPE]) begin
            ecode = ECODE_IPE;
        end
    end

endmodule

// File: rtl/excp_flush_ctrl.sv
// rtl/excp_flush_ctrl.sv - exception/ERTN flush sequencer with fetch redirect; optional counters via EXCP_FLUSH_CTRL_PERF_EN
module excp_flush_ctrl
    import excp_flush_ctrl_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int NCAUSE = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ws_valid,
    input  logic [PC_W-1:0]   ws_pc,
    input  logic [NCAUSE-1:0] ws_excp,
    input  logic [PC_W-1:0]   ws_badv,
    input  logic              ws_ertn,
    input  logic              has_int,
    input  logic [PC_W-1:0]   csr_eentry,
    input  logic [PC_W-1:0]   csr_era,
    output logic              ws_allowin,
    output logic              excp_flush,
    output logic              ertn_flush,
    output logic [PC_W-1:0]   era_in,
    output logic [5:0]        ecode_out,
    output logic [8:0]        esubcode_out,
    output logic [PC_W-1:0]   bad_va_out,
    output logic              va_error_out,
    output logic              pipe_flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
`ifdef EXCP_FLUSH_CTRL_PERF_EN
    output logic [31:0]       excp_cnt,
    output logic [31:0]       ertn_cnt,
`endif
    input  logic              redirect_ready
);

    state_t     state;
    logic       kind_excp;
    logic       take_excp;
    logic       take_ertn;
    logic       trigger;
    logic [5:0] enc_ecode;
    logic [8:0] enc_esubcode;
    logic       enc_va_error;

    excp_prio_enc #(.NCAUSE(NCAUSE)) u_prio_enc (
        .has_int  (has_int),
        .excp     (ws_excp),
        .ecode    (enc_ecode),
        .esubcode (enc_esubcode),
        .va_error (enc_va_error)
    );

    assign take_excp = has_int | (|ws_excp);
    assign take_ertn = ws_ertn & ~take_excp;
    assign trigger   = (state == ST_IDLE) & ws_valid & (take_excp | take_ertn);

    // The triggering instruction must not commit, so allowin drops in the same cycle.
    assign ws_allowin = (state == ST_IDLE) & ~trigger;
    assign pipe_flush = trigger | (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            kind_excp      <= 1'b0;
            excp_flush     <= 1'b0;
            ertn_flush     <= 1'b0;
            era_in         <= '0;
            ecode_out      <= '0;
            esubcode_out   <= '0;
            bad_va_out     <= '0;
            va_error_out   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
`ifdef EXCP_FLUSH_CTRL_PERF_EN
            excp_cnt       <= '0;
            ertn_cnt       <= '0;
`endif
        end else begin
            excp_flush <= 1'b0;
            ertn_flush <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state        <= ST_FLUSH;
                        kind_excp    <= take_excp;
                        excp_flush   <= take_excp;
                        ertn_flush   <= take_ertn;
                        era_in       <= ws_pc;
                        ecode_out    <= enc_ecode;
                        esubcode_out <= enc_esubcode;
                        va_error_out <= enc_va_error;
                        bad_va_out   <= enc_va_error ? ws_badv : '0;
                    end
                end
                ST_FLUSH: begin
                    // ERA is read before the CSR file applies this cycle's strobe.
                    redirect_pc    <= kind_excp ? csr_eentry : csr_era;
                    redirect_valid <= 1'b1;
                    state          <= ST_REDIR;
`ifdef EXCP_FLUSH_CTRL_PERF_EN
                    if (kind_excp) excp_cnt <= excp_cnt + 32'd1;
                    else           ertn_cnt <= ertn_cnt + 32'd1;
`endif
                end
                ST_REDIR: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    redirect_valid <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// tb/tb_excp_flush_ctrl.sv - directed self-checking bench for excp_flush_ctrl
module tb_excp_flush_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [5:0]  ws_excp;
    logic [31:0] ws_badv;
    logic        ws_ertn;
    logic        has_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        ws_allowin;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] era_in;
    logic [5:0]  ecode_out;
    logic [8:0]  esubcode_out;
    logic [31:0] bad_va_out;
    logic        va_error_out;
    logic        pipe_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
`ifdef EXCP_FLUSH_CTRL_PERF_EN
    logic [31:0] excp_cnt;
    logic [31:0] ertn_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    excp_flush_ctrl #(.PC_W(32), .NCAUSE(6)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ws_valid       (ws_valid),
        .ws_pc          (ws_pc),
        .ws_excp        (ws_excp),
        .ws_badv        (ws_badv),
        .ws_ertn        (ws_ertn),
        .has_int        (has_int),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
        .ws_allowin     (ws_allowin),
        .excp_flush     (excp_flush),
        .ertn_flush     (ertn_flush),
        .era_in         (era_in),
        .ecode_out      (ecode_out),
        .esubcode_out   (esubcode_out),
        .bad_va_out     (bad_va_out),
        .va_error_out   (va_error_out),
        .pipe_flush     (pipe_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef EXCP_FLUSH_CTRL_PERF_EN
        .excp_cnt       (excp_cnt),
        .ertn_cnt       (ertn_cnt),
`endif
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        ws_valid = 1'b0;
        ws_excp  = 6'b0;
        ws_ertn  = 1'b0;
        has_int  = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        quiet_inputs();
        ws_pc = '0; ws_badv = '0; csr_eentry = 32'h1c008000; csr_era = '0;
        redirect_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (ws_allowin !== 1'b1) begin n_bad++; $display("FAIL reset_allowin: got %b want 1", ws_allowin); end
        n_cmp++; if ({excp_flush, ertn_flush, redirect_valid, pipe_flush} !== 4'b0) begin n_bad++; $display("FAIL reset_strobes: got %b want 0000", {excp_flush, ertn_flush, redirect_valid, pipe_flush}); end
        n_cmp++; if (era_in !== 32'h0 || redirect_pc !== 32'h0 || ecode_out !== 6'h0) begin n_bad++; $display("FAIL reset_payload: era %h pc %h ecode %h want 0", era_in, redirect_pc, ecode_out); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_sync_excp();
        ws_valid = 1'b1; ws_excp = 6'b000100; ws_pc = 32'h1c000100;
        csr_eentry = 32'h1c008000; redirect_ready = 1'b1;
        #1;
        n_cmp++; if (ws_allowin !== 1'b0 || pipe_flush !== 1'b1) begin n_bad++; $display("FAIL sync_trigger_cycle: allowin %b flush %b want 0 1", ws_allowin, pipe_flush); end
        tick();
        quiet_inputs();
        n_cmp++; if (excp_flush !== 1'b1 || ertn_flush !== 1'b0) begin n_bad++; $display("FAIL sync_strobe: excp %b ertn %b want 1 0", excp_flush, ertn_flush); end
        n_cmp++; if (ecode_out !== 6'h0B || esubcode_out !== 9'h0 || va_error_out !== 1'b0) begin n_bad++; $display("FAIL sync_code: ecode %h sub %h va %b want 0b 0 0", ecode_out, esubcode_out, va_error_out); end
        n_cmp++; if (era_in !== 32'h1c000100) begin n_bad++; $display("FAIL sync_era: got %h want 1c000100", era_in); end
        n_cmp++; if (redirect_valid !== 1'b0 || ws_allowin !== 1'b0) begin n_bad++; $display("FAIL sync_flush_state: rv %b allowin %b want 0 0", redirect_valid, ws_allowin); end
        tick();
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c008000 || excp_flush !== 1'b0) begin n_bad++; $display("FAIL sync_redirect: rv %b pc %h excp %b want 1 1c008000 0", redirect_valid, redirect_pc, excp_flush); end
        tick();
        n_cmp++; if (redirect_valid !== 1'b0 || ws_allowin !== 1'b1 || pipe_flush !== 1'b0) begin n_bad++; $display("FAIL sync_idle: rv %b allowin %b flush %b want 0 1 0", redirect_valid, ws_allowin, pipe_flush); end
    endtask

    task automatic test_priority();
        ws_valid = 1'b1; has_int = 1'b1; ws_excp = 6'b000011; ws_badv = 32'h3; ws_pc = 32'h1c000110;
        tick();
        quiet_inputs();
        n_cmp++; if (ecode_out !== 6'h00 || va_error_out !== 1'b0 || excp_flush !== 1'b1) begin n_bad++; $display("FAIL prio_int: ecode %h va %b excp %b want 00 0 1", ecode_out, va_error_out, excp_flush); end
        tick(); tick();
        ws_valid = 1'b1; ws_excp = 6'b000011; ws_badv = 32'h3;
        tick();
        quiet_inputs();
        n_cmp++; if (ecode_out !== 6'h08 || bad_va_out !== 32'h3 || va_error_out !== 1'b1) begin n_bad++; $display("FAIL prio_adef: ecode %h badv %h va %b want 08 3 1", ecode_out, bad_va_out, va_error_out); end
        tick(); tick();
        ws_valid = 1'b1; ws_excp = 6'b110010; ws_badv = 32'h1c0000f6;
        tick();
        quiet_inputs();
        n_cmp++; if (ecode_out !== 6'h09 || bad_va_out !== 32'h1c0000f6 || va_error_out !== 1'b1) begin n_bad++; $display("FAIL prio_ale: ecode %h badv %h va %b want 09 1c0000f6 1", ecode_out, bad_va_out, va_error_out); end
        tick(); tick();
        ws_valid = 1'b1; ws_excp = 6'b101000;
        tick();
        quiet_inputs();
        n_cmp++; if (ecode_out !== 6'h0C || va_error_out !== 1'b0) begin n_bad++; $display("FAIL prio_brk: ecode %h va %b want 0c 0", ecode_out, va_error_out); end
        tick(); tick();
        ws_valid = 1'b1; ws_excp = 6'b100000;
        tick();
        quiet_inputs();
        n_cmp++; if (ecode_out !== 6'h0E) begin n_bad++; $display("FAIL prio_ipe: ecode %h want 0e", ecode_out); end
        tick(); tick();
    endtask

    task automatic test_ertn();
        ws_valid = 1'b1; ws_ertn = 1'b1; ws_pc = 32'h1c000300; csr_era = 32'h1c000200;
        tick();
        quiet_inputs();
        n_cmp++; if (ertn_flush !== 1'b1 || excp_flush !== 1'b0) begin n_bad++; $display("FAIL ertn_strobe: ertn %b excp %b want 1 0", ertn_flush, excp_flush); end
        tick();
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c000200 || ertn_flush !== 1'b0) begin n_bad++; $display("FAIL ertn_redirect: rv %b pc %h ertn %b want 1 1c000200 0", redirect_valid, redirect_pc, ertn_flush); end
        tick();
        ws_valid = 1'b1; ws_ertn = 1'b1; ws_excp = 6'b010000;
        tick();
        quiet_inputs();
        n_cmp++; if (excp_flush !== 1'b1 || ertn_flush !== 1'b0 || ecode_out !== 6'h0D) begin n_bad++; $display("FAIL ertn_ine: excp %b ertn %b ecode %h want 1 0 0d", excp_flush, ertn_flush, ecode_out); end
        tick();
        n_cmp++; if (redirect_pc !== 32'h1c008000) begin n_bad++; $display("FAIL ertn_ine_target: got %h want 1c008000", redirect_pc); end
        tick();
    endtask

    task automatic test_int_needs_valid();
        has_int = 1'b1; ws_valid = 1'b0;
        #1;
        n_cmp++; if (ws_allowin !== 1'b1 || pipe_flush !== 1'b0) begin n_bad++; $display("FAIL int_novalid_comb: allowin %b flush %b want 1 0", ws_allowin, pipe_flush); end
        tick();
        n_cmp++; if (excp_flush !== 1'b0 || pipe_flush !== 1'b0) begin n_bad++; $display("FAIL int_novalid_seq: excp %b flush %b want 0 0", excp_flush, pipe_flush); end
        quiet_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        redirect_ready = 1'b0;
        ws_valid = 1'b1; ws_excp = 6'b001000; ws_pc = 32'h1c000400; csr_eentry = 32'h1c00a000;
        tick();
        quiet_inputs();
        tick();
        csr_eentry = 32'h1c00b000;
        ws_valid = 1'b1; ws_excp = 6'b000010; has_int = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c00a000 || ws_allowin !== 1'b0) begin n_bad++; $display("FAIL bp_hold_%0d: rv %b pc %h allowin %b want 1 1c00a000 0", i, redirect_valid, redirect_pc, ws_allowin); end
            n_cmp++; if (excp_flush !== 1'b0 || ecode_out !== 6'h0C) begin n_bad++; $display("FAIL bp_ignore_%0d: excp %b ecode %h want 0 0c", i, excp_flush, ecode_out); end
            tick();
        end
        quiet_inputs();
        redirect_ready = 1'b1;
        tick();
        n_cmp++; if (redirect_valid !== 1'b0 || ws_allowin !== 1'b1 || era_in !== 32'h1c000400) begin n_bad++; $display("FAIL bp_release: rv %b allowin %b era %h want 0 1 1c000400", redirect_valid, ws_allowin, era_in); end
        csr_eentry = 32'h1c008000;
    endtask

    task automatic test_reset_mid();
        ws_valid = 1'b1; ws_excp = 6'b000100; ws_pc = 32'h1c000500;
        tick();
        quiet_inputs();
        resetn = 1'b0;
        #1;
        n_cmp++; if ({excp_flush, pipe_flush, redirect_valid} !== 3'b0 || ws_allowin !== 1'b1 || era_in !== 32'h0) begin n_bad++; $display("FAIL rst_flush: strobes %b allowin %b era %h want 000 1 0", {excp_flush, pipe_flush, redirect_valid}, ws_allowin, era_in); end
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({excp_flush, ertn_flush, redirect_valid, pipe_flush} !== 4'b0) begin n_bad++; $display("FAIL rst_flush_after_%0d: got %b want 0000", i, {excp_flush, ertn_flush, redirect_valid, pipe_flush}); end
        end
        redirect_ready = 1'b0;
        ws_valid = 1'b1; ws_ertn = 1'b1;
        tick();
        quiet_inputs();
        tick();
        n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL rst_redir_setup: rv %b want 1", redirect_valid); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || pipe_flush !== 1'b0) begin n_bad++; $display("FAIL rst_redir: rv %b pc %h flush %b want 0 0 0", redirect_valid, redirect_pc, pipe_flush); end
        tick();
        resetn = 1'b1;
        redirect_ready = 1'b1;
        tick(); tick();
        n_cmp++; if ({excp_flush, ertn_flush, redirect_valid} !== 3'b0 || ws_allowin !== 1'b1) begin n_bad++; $display("FAIL rst_redir_after: strobes %b allowin %b want 000 1", {excp_flush, ertn_flush, redirect_valid}, ws_allowin); end
    endtask

`ifdef EXCP_FLUSH_CTRL_PERF_EN
    task automatic test_perf();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        redirect_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ws_valid = 1'b1;
            if (i < 3) ws_excp = 6'b000100;
            else       ws_ertn = 1'b1;
            tick();
            quiet_inputs();
            tick(); tick();
        end
        n_cmp++; if (excp_cnt !== 32'd3 || ertn_cnt !== 32'd2) begin n_bad++; $display("FAIL perf_counts: excp %0d ertn %0d want 3 2", excp_cnt, ertn_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_sync_excp();
        test_priority();
        test_ertn();
        test_int_needs_valid();
        test_backpressure();
        test_reset_mid();
`ifdef EXCP_FLUSH_CTRL_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
